// File: rtl/dl_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package dl_shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  // First mux level owned by stage s; earlier stages absorb the remainder.
  function automatic int level_lo(int s, int num_stages, int num_shift_bits);
    return (s * num_shift_bits + num_stages - 1) / num_stages;
  endfunction

endpackage

// File: rtl/dl_shift_pipe_if.sv
// Issue-side and result-side handshake bundle for dl_shift_pipe.
interface dl_shift_pipe_if #(
  parameter int NUM_BITS = 32,
  parameter int TAG_BITS = 4
);
  import dl_shift_pkg::*;

  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_BITS-1:0]       in_data;
  logic [NUM_SHIFT_BITS-1:0] in_shamt;
  shift_op_e                 in_op;
  logic [TAG_BITS-1:0]       in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_BITS-1:0]       out_data;
  logic [TAG_BITS-1:0]       out_tag;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/dl_shift_pipe_stage.sv
// One pipeline stage: right-shift mux levels [LVL_LO, LVL_HI) followed by a register.
module dl_shift_stage
  import dl_shift_pkg::*;
#(
  parameter int NUM_BITS       = 32,
  parameter int NUM_SHIFT_BITS = 5,
  parameter int TAG_BITS       = 4,
  parameter int LVL_LO         = 0,
  parameter int LVL_HI         = 1,
  parameter bit RST_DATA       = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_i,
  input  logic [NUM_BITS-1:0]       data_i,
  input  logic [NUM_SHIFT_BITS-1:0] shamt_i,
  input  shift_op_e                 op_i,
  input  logic [TAG_BITS-1:0]       tag_i,
  input  logic                      adv_next_i,
  output logic                      adv_o,
  output logic                      vld_o,
  output logic [NUM_BITS-1:0]       data_o,
  output logic [NUM_SHIFT_BITS-1:0] shamt_o,
  output shift_op_e                 op_o,
  output logic [TAG_BITS-1:0]       tag_o
);

  logic                      vld_q;
  logic [NUM_BITS-1:0]       data_q, data_d;
  logic [NUM_SHIFT_BITS-1:0] shamt_q;
  shift_op_e                 op_q;
  logic [TAG_BITS-1:0]       tag_q;

  // SLL arrives bit-reversed, so every op is a right shift here.
  function automatic logic [NUM_BITS-1:0] shift_levels(
    input logic [NUM_BITS-1:0]       d,
    input logic [NUM_SHIFT_BITS-1:0] sh,
    input shift_op_e                 op
  );
    logic [NUM_BITS-1:0] r;
    r = d;
    for (int k = LVL_LO; k < LVL_HI; k++) begin
      if (sh[k]) begin
        case (op)
          ROR:     r = (r >> (1 << k)) | (r << (NUM_BITS - (1 << k)));
          SRA:     r = $unsigned($signed(r) >>> (1 << k));
          default: r = r >> (1 << k);
        endcase
      end
    end
    return r;
  endfunction

  assign data_d = shift_levels(data_i, shamt_i, op_i);
  assign adv_o  = !vld_q || adv_next_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (adv_o) begin
      vld_q <= vld_i;
    end
  end

  if (RST_DATA) begin : g_rst_data
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        shamt_q <= '0;
        op_q    <= SLL;
        tag_q   <= '0;
      end else if (adv_o) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        op_q    <= op_i;
        tag_q   <= tag_i;
      end
    end
  end else begin : g_no_rst_data
    always_ff @(posedge clk) begin
      if (adv_o) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        op_q    <= op_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/dl_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides and a sideband tag.
module dl_shift_pipe
  import dl_shift_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_BITS   = 4
) (
  input  logic           clk,
  input  logic           rst,
  dl_shift_pipe_if.slave bus
);

  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

  function automatic logic [NUM_BITS-1:0] bit_rev(input logic [NUM_BITS-1:0] d);
    logic [NUM_BITS-1:0] r;
    for (int i = 0; i < NUM_BITS; i++) r[i] = d[NUM_BITS-1-i];
    return r;
  endfunction

  // Index 0 is the input side, index NUM_STAGES the output register of the last stage.
  logic                      vld_s   [0:NUM_STAGES];
  logic                      adv_s   [0:NUM_STAGES];
  logic [NUM_BITS-1:0]       data_s  [0:NUM_STAGES];
  logic [NUM_SHIFT_BITS-1:0] shamt_s [0:NUM_STAGES];
  shift_op_e                 op_s    [0:NUM_STAGES];
  logic [TAG_BITS-1:0]       tag_s   [0:NUM_STAGES];

  assign vld_s[0]   = bus.in_valid;
  assign data_s[0]  = (bus.in_op == SLL) ? bit_rev(bus.in_data) : bus.in_data;
  assign shamt_s[0] = bus.in_shamt;
  assign op_s[0]    = bus.in_op;
  assign tag_s[0]   = bus.in_tag;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    dl_shift_stage #(
      .NUM_BITS      (NUM_BITS),
      .NUM_SHIFT_BITS(NUM_SHIFT_BITS),
      .TAG_BITS      (TAG_BITS),
      .LVL_LO        (level_lo(s, NUM_STAGES, NUM_SHIFT_BITS)),
      .LVL_HI        (level_lo(s + 1, NUM_STAGES, NUM_SHIFT_BITS)),
      .RST_DATA      (s == NUM_STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .vld_i     (vld_s[s]),
      .data_i    (data_s[s]),
      .shamt_i   (shamt_s[s]),
      .op_i      (op_s[s]),
      .tag_i     (tag_s[s]),
      .adv_next_i(adv_s[s+1]),
      .adv_o     (adv_s[s]),
      .vld_o     (vld_s[s+1]),
      .data_o    (data_s[s+1]),
      .shamt_o   (shamt_s[s+1]),
      .op_o      (op_s[s+1]),
      .tag_o     (tag_s[s+1])
    );
  end

  assign adv_s[NUM_STAGES] = !vld_s[NUM_STAGES] || bus.out_ready;

  // Stall chain is combinational end to end; nothing is accepted while in reset.
  assign bus.in_ready  = adv_s[0] && !rst;
  assign bus.out_valid = vld_s[NUM_STAGES];
  assign bus.out_data  = (op_s[NUM_STAGES] == SLL) ? bit_rev(data_s[NUM_STAGES])
                                                   : data_s[NUM_STAGES];
  assign bus.out_tag   = tag_s[NUM_STAGES];

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Bench for dl_shift_pipe: main 32-bit/2-stage instance plus latency/width sweep instances.
module tb_dl_shift_pipe;
  import dl_shift_pkg::*;

  localparam int MS = 2;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          acc;
  } sb_t;

  logic clk;
  logic rst;

  dl_shift_pipe_if #(.NUM_BITS(32), .TAG_BITS(4)) bm ();
  dl_shift_pipe_if #(.NUM_BITS(32), .TAG_BITS(4)) a1 ();
  dl_shift_pipe_if #(.NUM_BITS(32), .TAG_BITS(4)) a3 ();
  dl_shift_pipe_if #(.NUM_BITS(32), .TAG_BITS(4)) a5 ();
  dl_shift_pipe_if #(.NUM_BITS(8),  .TAG_BITS(4)) a8 ();

  dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(MS), .TAG_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bm));
  dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(1),  .TAG_BITS(4)) d1  (.clk(clk), .rst(rst), .bus(a1));
  dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(3),  .TAG_BITS(4)) d3  (.clk(clk), .rst(rst), .bus(a3));
  dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(5),  .TAG_BITS(4)) d5  (.clk(clk), .rst(rst), .bus(a5));
  dl_shift_pipe #(.NUM_BITS(8),  .NUM_STAGES(3),  .TAG_BITS(4)) d8  (.clk(clk), .rst(rst), .bus(a8));

  assign a1.in_valid = bm.in_valid;  assign a1.in_data = bm.in_data;
  assign a1.in_shamt = bm.in_shamt;  assign a1.in_op   = bm.in_op;
  assign a1.in_tag   = bm.in_tag;    assign a1.out_ready = 1'b1;
  assign a3.in_valid = bm.in_valid;  assign a3.in_data = bm.in_data;
  assign a3.in_shamt = bm.in_shamt;  assign a3.in_op   = bm.in_op;
  assign a3.in_tag   = bm.in_tag;    assign a3.out_ready = 1'b1;
  assign a5.in_valid = bm.in_valid;  assign a5.in_data = bm.in_data;
  assign a5.in_shamt = bm.in_shamt;  assign a5.in_op   = bm.in_op;
  assign a5.in_tag   = bm.in_tag;    assign a5.out_ready = 1'b1;
  assign a8.in_valid = bm.in_valid;  assign a8.in_data = bm.in_data[7:0];
  assign a8.in_shamt = bm.in_shamt[2:0]; assign a8.in_op = bm.in_op;
  assign a8.in_tag   = bm.in_tag;    assign a8.out_ready = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total, passed, fails;
  int          cyc;
  sb_t         sb[$];
  bit          lat_on, aux_on, use_dir, hold_pending;
  logic [31:0] dir_exp, held_d;
  logic [3:0]  held_t;
  int          aux_n;
  logic        hv [256];
  logic [31:0] hd [256];
  int          hs [256];
  int          ho [256];
  logic [3:0]  ht [256];

  function automatic logic [31:0] model(logic [31:0] d, int s, int op, int w);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & m;
    case (op)
      0:       r = (x << s) & m;
      1:       r = x >> s;
      2:       r = (x >> s) | (x[w-1] ? (m & ~(m >> s)) : 64'd0);
      default: r = ((x >> s) | (x << (w - s))) & m;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [31:0] d, int s, int op, logic [3:0] t);
    bm.in_valid = v;
    bm.in_data  = d;
    bm.in_shamt = 5'(s);
    bm.in_op    = shift_op_e'(op[1:0]);
    bm.in_tag   = t;
  endtask

  task automatic aux_chk(string nm, int lat, int w, logic vld, logic [31:0] dat, logic [3:0] tg);
    int  idx;
    bit  ev;
    idx = aux_n - lat;
    ev  = (idx >= 0) && (hv[idx] === 1'b1);
    chk({nm, "_valid"}, 32'(vld), 32'(ev));
    if (ev) begin
      chk({nm, "_data"}, dat, model(hd[idx], hs[idx] % w, ho[idx], w));
      chk({nm, "_tag"}, 32'(tg), 32'(ht[idx]));
    end
  endtask

  // One clock period: sample at negedge+2, then advance to the next negedge.
  task automatic step();
    sb_t e;
    #2;
    if (rst) begin
      sb.delete();
      hold_pending = 1'b0;
    end else begin
      chk("in_ready", 32'(bm.in_ready), 32'(!(sb.size() == MS && !bm.out_ready)));
      if (hold_pending) begin
        chk("hold_valid", 32'(bm.out_valid), 32'd1);
        chk("hold_data", bm.out_data, held_d);
        chk("hold_tag", 32'(bm.out_tag), 32'(held_t));
      end
      if (bm.out_valid && bm.out_ready) begin
        chk("pop_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", bm.out_data, e.d);
          chk("out_tag", 32'(bm.out_tag), 32'(e.t));
          if (lat_on) chk("latency", 32'(cyc - e.acc), 32'(MS));
        end
      end
      if (bm.in_valid && bm.in_ready) begin
        e.d   = use_dir ? dir_exp : model(bm.in_data, int'(bm.in_shamt), int'(bm.in_op), 32);
        e.t   = bm.in_tag;
        e.acc = cyc;
        sb.push_back(e);
      end
      hold_pending = bm.out_valid && !bm.out_ready;
      held_d = bm.out_data;
      held_t = bm.out_tag;
      if (aux_on) begin
        aux_chk("s1", 1, 32, a1.out_valid, a1.out_data, a1.out_tag);
        aux_chk("s3", 3, 32, a3.out_valid, a3.out_data, a3.out_tag);
        aux_chk("s5", 5, 32, a5.out_valid, a5.out_data, a5.out_tag);
        aux_chk("w8", 3, 8, a8.out_valid, {24'd0, a8.out_data}, a8.out_tag);
        hv[aux_n] = bm.in_valid;
        hd[aux_n] = bm.in_data;
        hs[aux_n] = int'(bm.in_shamt);
        ho[aux_n] = int'(bm.in_op);
        ht[aux_n] = bm.in_tag;
        aux_n++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  logic [31:0] t1e [4];
  logic [31:0] t2e [4];

  initial begin
    total = 0; passed = 0; fails = 0; cyc = 0; aux_n = 0;
    lat_on = 1'b1; aux_on = 1'b0; use_dir = 1'b0; hold_pending = 1'b0;
    dir_exp = '0; held_d = '0; held_t = '0;
    t1e = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000, 32'h1800_0000};
    t2e = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h4B4B_4B4B};
    rst = 1'b1;
    bm.out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 3, 1, 4'h7);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 0, 0, 4'h0);
    #1;
    chk("rst_out_valid", 32'(bm.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bm.in_ready), 32'd1);
    chk("rst_out_data", bm.out_data, 32'd0);
    chk("rst_out_tag", 32'(bm.out_tag), 32'd0);
    chk("rst_s5_valid", 32'(a5.out_valid), 32'd0);
    step();

    // Directed ops on 8000_0001 by 4, back to back.
    use_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir_exp = t1e[i];
      drive(1'b1, 32'h8000_0001, 4, i, 4'(i));
      step();
    end
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (4) step();

    // Shift amount extremes on A5A5_A5A5.
    for (int i = 0; i < 4; i++) begin
      use_dir = 1'b1;
      dir_exp = 32'hA5A5_A5A5;
      drive(1'b1, 32'hA5A5_A5A5, 0, i, 4'(2 * i));
      step();
      use_dir = (i != 1);
      dir_exp = t2e[i];
      drive(1'b1, 32'hA5A5_A5A5, 31, i, 4'(2 * i + 1));
      step();
    end
    use_dir = 1'b0;
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (4) step();

    // Back-to-back random stream, no backpressure.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom_range(0, 31), $urandom_range(0, 3), 4'(i));
      step();
    end
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (4) step();
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Random valid and random backpressure.
    lat_on = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bm.out_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 31), $urandom_range(0, 3), 4'(i));
      step();
    end
    bm.out_ready = 1'b1;
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (6) step();
    chk("random_drained", 32'(sb.size()), 32'd0);

    // Fill while stalled, then reset mid-flight.
    bm.out_ready = 1'b0;
    drive(1'b1, $urandom, 5, 1, 4'hA); step();
    drive(1'b1, $urandom, 6, 2, 4'hB); step();
    drive(1'b1, $urandom, 7, 3, 4'hC); step();
    rst = 1'b1;
    drive(1'b1, $urandom, 8, 0, 4'hD); step();
    rst = 1'b0;
    lat_on = 1'b1;
    bm.out_ready = 1'b1;
    drive(1'b1, $urandom, 9, 1, 4'h1);
    #1;
    chk("flush_out_valid", 32'(bm.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bm.in_ready), 32'd1);
    step();
    drive(1'b1, $urandom, 10, 2, 4'h2); step();
    drive(1'b1, $urandom, 11, 3, 4'h3); step();
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (6) step();
    chk("flush_drained", 32'(sb.size()), 32'd0);

    // Exhaustive shamt x op across all configurations.
    aux_on = 1'b1;
    aux_n  = 0;
    repeat (2) step();
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, $urandom, i % 32, i / 32, 4'(i));
      step();
    end
    drive(1'b0, '0, 0, 0, 4'h0);
    repeat (8) step();
    aux_on = 1'b0;
    chk("sweep_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
